// File: rtl/vga_pixel_receiver.sv
// Pixel-write receiver: clips drawer writes, buffers them in a FIFO and drains
// them to the frame-buffer port as linear addresses; also sweeps a full-screen clear.
module vga_pixel_receiver #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  pix_x,
  input  logic [6:0]  pix_y,
  input  logic [17:0] pix_colour,
  input  logic        pix_write,
  output logic        pix_ready,
  input  logic        clear_start,
  input  logic [17:0] clear_colour,
  output logic        clear_done,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic [14:0] mem_addr,
  output logic [17:0] mem_data,
  output logic        mem_we,
  input  logic        mem_stall,
  output logic [1:0]  dbg_state
);

  // Handshakes: a pixel transfers on pix_write && pix_ready (no retry, a refused
  // strobe is dropped); a frame-buffer write transfers on mem_we && !mem_stall,
  // and mem_addr/mem_data stay stable while mem_we && mem_stall.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [8:0]  X_LIM = 9'(WIDTH);
  localparam logic [7:0]  Y_LIM = 8'(HEIGHT);
  localparam logic [14:0] W15   = 15'(WIDTH);
  localparam logic [14:0] TOTAL = 15'(WIDTH * HEIGHT);
  localparam logic [14:0] LAST  = 15'(WIDTH * HEIGHT - 1);

  state_t state, state_next;

  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_full, fifo_empty;

  logic          clear_pending;
  logic [17:0]   clear_col;
  logic [14:0]   sweep_cnt;

  logic          on_screen, accept, drop;
  logic          out_take, out_free, drain, sweep_load;
  logic [32:0]   head;
  logic [14:0]   head_addr;

  // Depth is a power of two, so the top count bit alone marks "full".
  assign fifo_full  = count[PW];
  assign fifo_empty = (count == '0);

  assign on_screen = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);
  assign pix_ready = !fifo_full && (state == S_IDLE) && !clear_pending;
  assign accept    = pix_write && pix_ready && on_screen;
  assign drop      = pix_write && !accept;

  assign out_take   = mem_we && !mem_stall;
  assign out_free   = !mem_we || out_take;
  assign drain      = (state == S_IDLE) && !fifo_empty && out_free;
  assign sweep_load = (state == S_CLEAR) && out_free && (sweep_cnt != TOTAL);

  assign head      = fifo_mem[rd_ptr];
  assign head_addr = {8'd0, head[24:18]} * W15 + {7'd0, head[32:25]};

  assign clear_done = (state == S_DONE);
  assign busy       = !fifo_empty || mem_we || (state != S_IDLE) || clear_pending;
  assign dbg_state  = state;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (clear_pending && fifo_empty && !mem_we) state_next = S_CLEAR;
      S_CLEAR: if (out_take && (mem_addr == LAST)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) fifo_mem[wr_ptr] <= {pix_x, pix_y, pix_colour};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (drain)  rd_ptr <= rd_ptr + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Single output register: loads from the FIFO head while idle, from the sweep while clearing.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (drain) begin
      mem_we   <= 1'b1;
      mem_addr <= head_addr;
      mem_data <= head[17:0];
    end else if (sweep_load) begin
      mem_we   <= 1'b1;
      mem_addr <= sweep_cnt;
      mem_data <= clear_col;
    end else if (out_take) begin
      mem_we   <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (state != S_CLEAR)) sweep_cnt <= '0;
    else if (sweep_load)             sweep_cnt <= sweep_cnt + 15'd1;
  end

  // Only the first request is captured; later ones are ignored until the fill completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_pending <= 1'b0;
      clear_col     <= '0;
    end else if (state == S_DONE) begin
      clear_pending <= 1'b0;
    end else if (clear_start && (state == S_IDLE) && !clear_pending) begin
      clear_pending <= 1'b1;
      clear_col     <= clear_colour;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                            drop_count <= '0;
    else if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
  end

endmodule

// File: tb/tb_vga_pixel_receiver.sv
// Directed bench for vga_pixel_receiver: vector table for single-pixel/clipping
// behaviour, plus hand-written burst, clear, pending-clear and reset sequences.
module tb_vga_pixel_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [17:0] pix_colour;
  logic        pix_write;
  logic        pix_ready;
  logic        clear_start;
  logic [17:0] clear_colour;
  logic        clear_done;
  logic        busy;
  logic [7:0]  drop_count;
  logic [14:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_we;
  logic        mem_stall;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];

  vga_pixel_receiver #(.WIDTH(160), .HEIGHT(120), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .pix_write(pix_write), .pix_ready(pix_ready),
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
    .busy(busy), .drop_count(drop_count),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_stall(mem_stall),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pix_write   = 1'b0;
    clear_start = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    pix_colour  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    mem_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_pix(input int x, input int y, input logic [17:0] c);
    pix_write  = 1'b1;
    pix_x      = 8'(x);
    pix_y      = 7'(y);
    pix_colour = c;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [17:0] c;
    logic        e_we;
    logic [14:0] e_addr;
    logic [17:0] e_data;
    logic        e_ready;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int takes, bad, busy_low, stall_left, cyc;
    logic done, w_done, c_done, s_done, hit;
    logic [14:0] exp_addr;
    logic [32:0] e;

    vecs[0]  = '{1'b1, 8'd10,  7'd5,   18'h15555, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd0};
    vecs[1]  = '{1'b0, 8'd0,   7'd0,   18'h00000, 1'b1, 15'd810,   18'h15555, 1'b1, 8'd0};
    vecs[2]  = '{1'b1, 8'd160, 7'd0,   18'h00001, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd1};
    vecs[3]  = '{1'b1, 8'd0,   7'd120, 18'h00001, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd2};
    vecs[4]  = '{1'b1, 8'd159, 7'd119, 18'h3FFFF, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd2};
    vecs[5]  = '{1'b0, 8'd0,   7'd0,   18'h00000, 1'b1, 15'd19199, 18'h3FFFF, 1'b1, 8'd2};
    vecs[6]  = '{1'b0, 8'd0,   7'd0,   18'h00000, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 8'd1,   7'd0,   18'h00001, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd2};
    vecs[8]  = '{1'b1, 8'd2,   7'd0,   18'h00002, 1'b1, 15'd1,     18'h00001, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 8'd0,   7'd0,   18'h00000, 1'b1, 15'd2,     18'h00002, 1'b1, 8'd2};
    vecs[10] = '{1'b0, 8'd0,   7'd0,   18'h00000, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd2};
    vecs[11] = '{1'b1, 8'd255, 7'd127, 18'h00003, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd3};
    vecs[12] = '{1'b1, 8'd159, 7'd0,   18'h0002A, 1'b0, 15'd0,     18'h00000, 1'b1, 8'd3};
    vecs[13] = '{1'b0, 8'd0,   7'd0,   18'h00000, 1'b1, 15'd159,   18'h0002A, 1'b1, 8'd3};

    // reset state
    do_reset();
    check("reset_we",    32'(mem_we),     32'd0);
    check("reset_addr",  32'(mem_addr),   32'd0);
    check("reset_data",  32'(mem_data),   32'd0);
    check("reset_drop",  32'(drop_count), 32'd0);
    check("reset_done",  32'(clear_done), 32'd0);
    check("reset_busy",  32'(busy),       32'd0);
    check("reset_ready", 32'(pix_ready),  32'd1);
    check("reset_state", 32'(dbg_state),  32'd0);

    // vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) write_pix(int'(vecs[i].x), int'(vecs[i].y), vecs[i].c);
      else            pix_write = 1'b0;
      tick();
      check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
        check($sformatf("vec%0d_data", i), 32'(mem_data), 32'(vecs[i].e_data));
      end
      check($sformatf("vec%0d_ready", i), 32'(pix_ready),  32'(vecs[i].e_ready));
      check($sformatf("vec%0d_drop", i),  32'(drop_count), 32'(vecs[i].e_drop));
    end
    pix_write = 1'b0;

    // burst into a stalled frame buffer: output register + 8 FIFO entries fill up
    do_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_pix(i, 1, 18'(i * 16 + 5));
      exp_q.push_back({15'(160 + i), 18'(i * 16 + 5)});
      tick();
      check($sformatf("burst_ready%0d", i), 32'(pix_ready), (i < 8) ? 32'd1 : 32'd0);
    end
    write_pix(20, 1, 18'h00FFF);
    tick();
    pix_write = 1'b0;
    check("burst_drop",      32'(drop_count), 32'd1);
    check("burst_hold_we",   32'(mem_we),     32'd1);
    check("burst_hold_addr", 32'(mem_addr),   32'd160);
    mem_stall = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      if (mem_we) begin
        e = exp_q.pop_front();
        check("burst_addr", 32'(mem_addr), 32'(e[32:18]));
        check("burst_data", 32'(mem_data), 32'(e[17:0]));
      end
      tick();
      cyc++;
    end
    check("burst_cycles",  32'(cyc),       32'd9);
    check("burst_we_end",  32'(mem_we),    32'd0);
    check("burst_ready_e", 32'(pix_ready), 32'd1);
    exp_q.delete();

    // full-screen clear with a dropped write, an ignored restart and a stall burst
    do_reset();
    clear_start  = 1'b1;
    clear_colour = 18'h0ABCD;
    tick();
    clear_start  = 1'b0;
    clear_colour = 18'h3FFFF;
    check("clear_busy0",  32'(busy),      32'd1);
    check("clear_ready0", 32'(pix_ready), 32'd0);
    takes = 0; bad = 0; exp_addr = '0; done = 1'b0;
    w_done = 1'b0; c_done = 1'b0; s_done = 1'b0; stall_left = 0;
    for (int c = 0; c < 25000; c++) begin
      if (clear_done) begin done = 1'b1; break; end
      pix_write = 1'b0; clear_start = 1'b0;
      if (exp_addr == 15'd1000 && !w_done) begin write_pix(3, 3, 18'h1); w_done = 1'b1; end
      if (exp_addr == 15'd2000 && !c_done) begin
        clear_start = 1'b1; clear_colour = 18'h11111; c_done = 1'b1;
      end
      if (exp_addr == 15'd3000 && !s_done) begin stall_left = 3; s_done = 1'b1; end
      mem_stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (mem_we && !mem_stall) begin
        if (mem_addr !== exp_addr || mem_data !== 18'h0ABCD) begin
          if (bad == 0) $display("FAIL clear_seq actual=%0d/%0h required=%0d/0abcd",
                                 mem_addr, mem_data, exp_addr);
          bad++;
        end
        exp_addr++;
        takes++;
      end
      tick();
    end
    idle_inputs();
    mem_stall = 1'b0;
    check("clear_done_seen", 32'(done),       32'd1);
    check("clear_takes",     32'(takes),      32'd19200);
    check("clear_bad",       32'(bad),        32'd0);
    check("clear_drop",      32'(drop_count), 32'd1);
    tick();
    check("clear_done_once", 32'(clear_done), 32'd0);
    check("clear_busy_end",  32'(busy),       32'd0);
    check("clear_state_end", 32'(dbg_state),  32'd0);
    check("clear_ready_end", 32'(pix_ready),  32'd1);

    // clear requested while pixels are still buffered
    do_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_pix(5 + i, 2, 18'(i + 7));
      exp_q.push_back({15'(325 + i), 18'(i + 7)});
      tick();
    end
    pix_write    = 1'b0;
    clear_start  = 1'b1;
    clear_colour = 18'h00777;
    tick();
    clear_start = 1'b0;
    check("pend_ready", 32'(pix_ready), 32'd0);
    check("pend_busy",  32'(busy),      32'd1);
    mem_stall = 1'b0;
    takes = 0; bad = 0; busy_low = 0; exp_addr = '0; done = 1'b0;
    for (int c = 0; c < 25000; c++) begin
      if (!busy) busy_low++;
      if (clear_done) begin done = 1'b1; break; end
      if (mem_we) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pend_pix_addr", 32'(mem_addr), 32'(e[32:18]));
          check("pend_pix_data", 32'(mem_data), 32'(e[17:0]));
        end else begin
          if (mem_addr !== exp_addr || mem_data !== 18'h00777) begin
            if (bad == 0) $display("FAIL pend_seq actual=%0d/%0h required=%0d/00777",
                                   mem_addr, mem_data, exp_addr);
            bad++;
          end
          exp_addr++;
          takes++;
        end
      end
      tick();
    end
    check("pend_done_seen", 32'(done),          32'd1);
    check("pend_queue",     32'(exp_q.size()),  32'd0);
    check("pend_takes",     32'(takes),         32'd19200);
    check("pend_bad",       32'(bad),           32'd0);
    check("pend_busy_low",  32'(busy_low),      32'd0);
    tick();
    check("pend_busy_end",  32'(busy),          32'd0);
    exp_q.delete();

    // reset in the middle of a sweep
    do_reset();
    clear_start  = 1'b1;
    clear_colour = 18'h0F0F0;
    tick();
    clear_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (mem_we && mem_addr == 15'd500) begin hit = 1'b1; break; end
      tick();
    end
    check("rst_reached_500", 32'(hit), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    reset = 1'b0;
    tick();
    check("rst_we_after",    32'(mem_we),    32'd0);
    check("rst_ready_after", 32'(pix_ready), 32'd1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) begin
      write_pix(200, 0, 18'h0);
      tick();
      if (i == 253) check("sat_254", 32'(drop_count), 32'd254);
      if (i == 254) check("sat_255", 32'(drop_count), 32'd255);
    end
    pix_write = 1'b0;
    check("sat_hold", 32'(drop_count), 32'd255);
    check("sat_we",   32'(mem_we),     32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
